// File: rtl/lcd_pkg.sv
// Shared types and constants for the LCD text feeder: FSM states, HD44780-style
// command codes and the {rs, rw, data} layout of the controller bus.
package lcd_pkg;

    typedef enum logic [1:0] {
        WAIT_INIT = 2'd0,
        IDLE      = 2'd1,
        ISSUE     = 2'd2,
        DRAIN     = 2'd3
    } feed_state_e;

    localparam int BUS_W        = 10;
    localparam int BUS_RS       = 9;
    localparam int BUS_RW       = 8;
    localparam int BUS_DATA_MSB = 7;
    localparam int BUS_DATA_LSB = 0;

    localparam logic [7:0] CMD_CLEAR     = 8'h01;
    localparam logic [7:0] CMD_SET_DDRAM = 8'h80;
    localparam logic [7:0] ROW0_BASE     = 8'h00;
    localparam logic [7:0] ROW1_BASE     = 8'h40;
    localparam logic [7:0] CHAR_LF       = 8'h0A;

    function automatic logic [BUS_W-1:0] pack_bus(input logic rs, input logic rw,
                                                  input logic [7:0] data);
        logic [BUS_W-1:0] b;
        b                            = '0;
        b[BUS_RS]                    = rs;
        b[BUS_RW]                    = rw;
        b[BUS_DATA_MSB:BUS_DATA_LSB] = data;
        return b;
    endfunction

endpackage

// File: rtl/lcd_char_fifo.sv
// Synchronous character FIFO with full/empty flags; DEPTH must be a power of two.
module lcd_char_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW:0]      wr_ptr_q, wr_ptr_d;
    logic [AW:0]      rd_ptr_q, rd_ptr_d;
    logic             do_push, do_pop;

    // Extra pointer MSB distinguishes full from empty when the indices match.
    assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign empty   = (wr_ptr_q == rd_ptr_q);
    assign rdata   = mem_q[rd_ptr_q[AW-1:0]];
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    always_comb begin
        wr_ptr_d = wr_ptr_q + {{AW{1'b0}}, do_push};
        rd_ptr_d = rd_ptr_q + {{AW{1'b0}}, do_pop};
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // NOTE: storage is deliberately left out of reset; the pointers alone define
    // which entries are valid, so resetting the array would only cost flops.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= wdata;
    end

endmodule

// File: rtl/lcd_text_feeder.sv
// Feeds queued ASCII characters and clear commands to an LCD controller using a
// busy-flag handshake. Define LCD_FEED_WRAP_EN for cursor tracking, line wrap and newline.
module lcd_text_feeder
    import lcd_pkg::*;
#(
    parameter int COLS       = 16,
    parameter int ROWS       = 2,
    parameter int FIFO_DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             char_valid,
    input  logic [7:0]       char_data,
    output logic             char_ready,
    input  logic             clear_req,
    input  logic             busy,
    output logic             lcd_enable,
    output logic [BUS_W-1:0] lcd_bus
);

    if (COLS < 4 || COLS > 40 || !(ROWS == 1 || ROWS == 2) || FIFO_DEPTH < 2 ||
        FIFO_DEPTH > 16 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_cfg
        $error("lcd_text_feeder: unsupported COLS/ROWS/FIFO_DEPTH");
    end

    feed_state_e      state_q, state_d;
    logic             busy_seen_q, busy_seen_d;
    logic             clear_pend_q, clear_pend_d;
    logic             rdy_q, rdy_d;
    logic [BUS_W-1:0] bus_q, bus_d;
    logic             fifo_full, fifo_empty, fifo_pop;
    logic [7:0]       fifo_rdata;

`ifdef LCD_FEED_WRAP_EN
    localparam int         CW       = $clog2(COLS);
    localparam logic [CW-1:0] COL_LAST = CW'(COLS - 1);

    logic [CW-1:0] col_q, col_d;
    logic          row_q, row_d;
    logic          row_pend_q, row_pend_d;
    logic          next_row;

    assign next_row = (ROWS == 2) ? ~row_q : 1'b0;
`endif

    assign char_ready = rdy_q && !fifo_full;
    assign lcd_enable = (state_q == ISSUE);
    assign lcd_bus    = bus_q;

    lcd_char_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(8)) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (char_valid && char_ready),
        .wdata (char_data),
        .pop   (fifo_pop),
        .rdata (fifo_rdata),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    // NOTE: every signal gets a default before the case so no path can infer a latch.
    always_comb begin
        state_d      = state_q;
        busy_seen_d  = busy_seen_q;
        clear_pend_d = clear_pend_q || clear_req;
        rdy_d        = 1'b1;
        bus_d        = bus_q;
        fifo_pop     = 1'b0;
`ifdef LCD_FEED_WRAP_EN
        col_d        = col_q;
        row_d        = row_q;
        row_pend_d   = row_pend_q;
`endif
        unique case (state_q)
            WAIT_INIT: begin
                if (busy)             busy_seen_d = 1'b1;
                else if (busy_seen_q) state_d     = IDLE;
            end
            IDLE: begin
                if (clear_pend_q) begin
                    bus_d        = pack_bus(1'b0, 1'b0, CMD_CLEAR);
                    clear_pend_d = clear_req;
                    state_d      = ISSUE;
`ifdef LCD_FEED_WRAP_EN
                    col_d        = '0;
                    row_d        = 1'b0;
                    row_pend_d   = 1'b0;
                end else if (row_pend_q) begin
                    bus_d      = pack_bus(1'b0, 1'b0,
                                          CMD_SET_DDRAM | (next_row ? ROW1_BASE : ROW0_BASE));
                    row_d      = next_row;
                    row_pend_d = 1'b0;
                    state_d    = ISSUE;
                end else if (!fifo_empty) begin
                    fifo_pop = 1'b1;
                    // A newline only moves the cursor; it is never written as data.
                    if (fifo_rdata == CHAR_LF) begin
                        row_pend_d = 1'b1;
                        col_d      = '0;
                    end else begin
                        bus_d   = pack_bus(1'b1, 1'b0, fifo_rdata);
                        state_d = ISSUE;
                        if (col_q == COL_LAST) begin
                            col_d      = '0;
                            row_pend_d = 1'b1;
                        end else begin
                            col_d = col_q + 1'b1;
                        end
                    end
                end
`else
                end else if (!fifo_empty) begin
                    fifo_pop = 1'b1;
                    bus_d    = pack_bus(1'b1, 1'b0, fifo_rdata);
                    state_d  = ISSUE;
                end
`endif
            end
            ISSUE: if (busy)  state_d = DRAIN;
            DRAIN: if (!busy) state_d = IDLE;
            default:          state_d = WAIT_INIT;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so all flops update together.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= WAIT_INIT;
            busy_seen_q  <= 1'b0;
            clear_pend_q <= 1'b0;
            rdy_q        <= 1'b0;
            bus_q        <= '0;
`ifdef LCD_FEED_WRAP_EN
            col_q        <= '0;
            row_q        <= 1'b0;
            row_pend_q   <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            busy_seen_q  <= busy_seen_d;
            clear_pend_q <= clear_pend_d;
            rdy_q        <= rdy_d;
            bus_q        <= bus_d;
`ifdef LCD_FEED_WRAP_EN
            col_q        <= col_d;
            row_q        <= row_d;
            row_pend_q   <= row_pend_d;
`endif
        end
    end

endmodule
